// File: rtl/buffer_escrita.sv
// buffer_escrita
// Write-side front end for the 8x8 register bank. Result writes arrive through a
// valid/ready handshake and are queued in a small circular FIFO of {addr, data}.
// One entry per cycle is drained into a registered output stage that drives the
// bank write port. Because the bank cannot see a same-edge write on its read
// ports, the block also forwards the newest pending value for two queried
// addresses.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   inValid/inReady      producer handshake; inAdd/inDado carry the request
//   stall                hold the bank write port (no drain this cycle)
//   flush                discard every queued entry
//   wrEn/addWr/dadoWr    registered bank write port
//   addQ1/addQ2          addresses the bank is reading this cycle
//   hit1/hit2, fwd1/fwd2 pending-write hit flags and newest pending data
//   count                entries held in the FIFO (output register excluded)
module buffer_escrita #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [AW-1:0]            inAdd,
    input  logic [DW-1:0]            inDado,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     wrEn,
    output logic [AW-1:0]            addWr,
    output logic [DW-1:0]            dadoWr,
    input  logic [AW-1:0]            addQ1,
    input  logic [AW-1:0]            addQ2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DW-1:0]            fwd1,
    output logic [DW-1:0]            fwd2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem_r [DEPTH];
    logic [DW-1:0] data_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          wr_en_r;
    logic [AW-1:0] add_wr_r;
    logic [DW-1:0] dado_wr_r;

    logic          full_s;
    logic          empty_s;
    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic          hit1_s;
    logic          hit2_s;
    logic [DW-1:0] fwd1_s;
    logic [DW-1:0] fwd2_s;

    // Handshake and FIFO control; a full FIFO refuses a push even when it pops.
    always_comb begin
        full_s  = (count_r == CW'(DEPTH));
        empty_s = (count_r == {CW{1'b0}});
        ready_s = !full_s && !flush;
        push_s  = inValid && ready_s;
        pop_s   = !stall && !flush && !empty_s;
    end

    // FIFO storage; contents beyond count are never observed, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            addr_mem_r[wr_ptr_r] <= inAdd;
            data_mem_r[wr_ptr_r] <= inDado;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered bank write port; address/data hold while stalled or flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            add_wr_r  <= {AW{1'b0}};
            dado_wr_r <= {DW{1'b0}};
        end else if (flush || stall) begin
            wr_en_r   <= 1'b0;
        end else if (!empty_s) begin
            wr_en_r   <= 1'b1;
            add_wr_r  <= addr_mem_r[rd_ptr_r];
            dado_wr_r <= data_mem_r[rd_ptr_r];
        end else begin
            wr_en_r   <= 1'b0;
        end
    end

    // Forwarding: scan oldest (output register) to newest FIFO entry so the
    // last match seen is the most recently pushed one.
    always_comb begin
        logic [PW-1:0] idx_v;
        logic          vld_v;
        logic          m1_v;
        logic          m2_v;
        idx_v  = {PW{1'b0}};
        vld_v  = 1'b0;
        m1_v   = wr_en_r && (add_wr_r == addQ1);
        m2_v   = wr_en_r && (add_wr_r == addQ2);
        hit1_s = m1_v;
        hit2_s = m2_v;
        fwd1_s = m1_v ? dado_wr_r : {DW{1'b0}};
        fwd2_s = m2_v ? dado_wr_r : {DW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_v  = rd_ptr_r + PW'(i);
            vld_v  = (CW'(i) < count_r);
            m1_v   = vld_v && (addr_mem_r[idx_v] == addQ1);
            m2_v   = vld_v && (addr_mem_r[idx_v] == addQ2);
            hit1_s = hit1_s | m1_v;
            hit2_s = hit2_s | m2_v;
            fwd1_s = m1_v ? data_mem_r[idx_v] : fwd1_s;
            fwd2_s = m2_v ? data_mem_r[idx_v] : fwd2_s;
        end
    end

    assign inReady = ready_s;
    assign wrEn    = wr_en_r;
    assign addWr   = add_wr_r;
    assign dadoWr  = dado_wr_r;
    assign count   = count_r;
    assign hit1    = hit1_s;
    assign hit2    = hit2_s;
    assign fwd1    = fwd1_s;
    assign fwd2    = fwd2_s;

endmodule

// File: tb/tb_buffer_escrita.sv
module tb_buffer_escrita;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [AW-1:0] inAdd = 3'd0;
    logic [DW-1:0] inDado = 8'd0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          wrEn;
    logic [AW-1:0] addWr;
    logic [DW-1:0] dadoWr;
    logic [AW-1:0] addQ1 = 3'd0;
    logic [AW-1:0] addQ2 = 3'd0;
    logic          hit1, hit2;
    logic [DW-1:0] fwd1, fwd2;
    logic [CW-1:0] count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending FIFO as a queue plus the presented write.
    logic [AW+DW-1:0] m_q[$];
    logic             m_v = 1'b0;
    logic [AW-1:0]    m_a = 3'd0;
    logic [DW-1:0]    m_d = 8'd0;

    buffer_escrita #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .inAdd(inAdd), .inDado(inDado), .stall(stall), .flush(flush),
        .wrEn(wrEn), .addWr(addWr), .dadoWr(dadoWr),
        .addQ1(addQ1), .addQ2(addQ2), .hit1(hit1), .hit2(hit2),
        .fwd1(fwd1), .fwd2(fwd2), .count(count)
    );

    always #5 clk = ~clk;

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic tick();
        bit ready;
        @(posedge clk);
        if (rst) begin
            m_q.delete(); m_v = 1'b0; m_a = 3'd0; m_d = 8'd0;
        end else if (flush) begin
            m_q.delete(); m_v = 1'b0;
        end else begin
            ready = (m_q.size() < DEPTH);
            if (!stall && m_q.size() > 0) begin
                {m_a, m_d} = m_q.pop_front();
                m_v = 1'b1;
            end else begin
                m_v = 1'b0;
            end
            if (inValid && ready) m_q.push_back({inAdd, inDado});
        end
        #1;
    endtask

    // Newest pending value for an address: {hit, data}.
    function automatic logic [DW:0] ref_fwd(input logic [AW-1:0] a);
        logic [DW:0] r;
        r = {1'b0, 8'd0};
        if (m_v && m_a == a) r = {1'b1, m_d};
        for (int i = 0; i < m_q.size(); i++)
            if (m_q[i][AW+DW-1:DW] == a) r = {1'b1, m_q[i][DW-1:0]};
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; inValid = 1'b1; inAdd = 3'd5; inDado = 8'h77;
        tick(); tick();
        rst = 1'b0; inValid = 1'b0; addQ1 = 3'd5; addQ2 = 3'd0;
        #1;
        vectors++; if (wrEn !== 1'b0) begin miscompares++; $display("FAIL reset_wrEn got=%0b exp=0", wrEn); end
        vectors++; if (addWr !== 3'd0) begin miscompares++; $display("FAIL reset_addWr got=%0d exp=0", addWr); end
        vectors++; if (dadoWr !== 8'd0) begin miscompares++; $display("FAIL reset_dadoWr got=%h exp=00", dadoWr); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++; if (inReady !== 1'b1) begin miscompares++; $display("FAIL reset_inReady got=%0b exp=1", inReady); end
        vectors++; if (hit1 !== 1'b0 || fwd1 !== 8'd0) begin miscompares++; $display("FAIL reset_fwd got=%0b/%h exp=0/00", hit1, fwd1); end
    endtask

    task automatic test_single();
        inValid = 1'b1; inAdd = 3'd3; inDado = 8'hA5;
        tick();
        inValid = 1'b0;
        vectors++; if (wrEn !== 1'b0 || count !== 3'd1) begin miscompares++; $display("FAIL single_queued got wrEn=%0b count=%0d exp 0/1", wrEn, count); end
        tick();
        vectors++; if (wrEn !== 1'b1 || addWr !== 3'd3 || dadoWr !== 8'hA5) begin miscompares++; $display("FAIL single_write got %0b/%0d/%h exp 1/3/a5", wrEn, addWr, dadoWr); end
        tick();
        vectors++; if (wrEn !== 1'b0) begin miscompares++; $display("FAIL single_done got wrEn=%0b exp=0", wrEn); end
    endtask

    task automatic test_fill();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inValid = 1'b1; inAdd = AW'(i); inDado = 8'h10 + 8'(i);
            tick();
        end
        inValid = 1'b0;
        vectors++; if (count !== 3'd4 || inReady !== 1'b0) begin miscompares++; $display("FAIL fill_full got count=%0d inReady=%0b exp 4/0", count, inReady); end
        vectors++; if (wrEn !== 1'b0) begin miscompares++; $display("FAIL fill_stalled got wrEn=%0b exp=0", wrEn); end
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (wrEn !== 1'b1 || addWr !== AW'(k) || dadoWr !== 8'h10 + 8'(k)) begin
                miscompares++; $display("FAIL fill_drain%0d got %0b/%0d/%h exp 1/%0d/%h", k, wrEn, addWr, dadoWr, k, 8'h10 + 8'(k));
            end
        end
        vectors++; if (inReady !== 1'b1 || count !== 3'd0) begin miscompares++; $display("FAIL fill_ready got inReady=%0b count=%0d exp 1/0", inReady, count); end
        tick();
        vectors++; if (wrEn !== 1'b0) begin miscompares++; $display("FAIL fill_extra got wrEn=%0b exp=0", wrEn); end
    endtask

    task automatic test_fwd();
        stall = 1'b1;
        inValid = 1'b1; inAdd = 3'd5; inDado = 8'h11; tick();
        inDado = 8'h22; tick();
        inValid = 1'b0; addQ1 = 3'd5; addQ2 = 3'd6; #1;
        vectors++; if (hit1 !== 1'b1 || fwd1 !== 8'h22) begin miscompares++; $display("FAIL fwd_newest got %0b/%h exp 1/22", hit1, fwd1); end
        vectors++; if (hit2 !== 1'b0 || fwd2 !== 8'h00) begin miscompares++; $display("FAIL fwd_miss got %0b/%h exp 0/00", hit2, fwd2); end
        stall = 1'b0;
        tick();
        vectors++; if (wrEn !== 1'b1 || hit1 !== 1'b1 || fwd1 !== 8'h22) begin miscompares++; $display("FAIL fwd_over_out got %0b/%0b/%h exp 1/1/22", wrEn, hit1, fwd1); end
        tick();
        vectors++; if (hit1 !== 1'b1 || fwd1 !== 8'h22) begin miscompares++; $display("FAIL fwd_outreg got %0b/%h exp 1/22", hit1, fwd1); end
        tick();
        vectors++; if (wrEn !== 1'b0 || hit1 !== 1'b0 || fwd1 !== 8'h00) begin miscompares++; $display("FAIL fwd_clear got %0b/%0b/%h exp 0/0/00", wrEn, hit1, fwd1); end
    endtask

    task automatic test_flush();
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            inValid = 1'b1; inAdd = AW'(i); inDado = 8'hC0 + 8'(i);
            tick();
        end
        inValid = 1'b0; stall = 1'b0;
        tick();
        vectors++; if (wrEn !== 1'b1 || addWr !== 3'd1 || dadoWr !== 8'hC1 || count !== 3'd3) begin
            miscompares++; $display("FAIL flush_present got %0b/%0d/%h/%0d exp 1/1/c1/3", wrEn, addWr, dadoWr, count);
        end
        flush = 1'b1; inValid = 1'b1; inAdd = 3'd7; inDado = 8'hFF; #1;
        vectors++; if (inReady !== 1'b0) begin miscompares++; $display("FAIL flush_ready got=%0b exp=0", inReady); end
        tick();
        flush = 1'b0; inValid = 1'b0;
        vectors++; if (wrEn !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL flush_clear got %0b/%0d exp 0/0", wrEn, count); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (wrEn !== 1'b0) begin miscompares++; $display("FAIL flush_ghost%0d got wrEn=%0b addWr=%0d exp wrEn=0", k, wrEn, addWr); end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] addrs[11];
        for (int i = 1; i <= 10; i++) begin
            inValid = 1'b1; inAdd = AW'($urandom); inDado = 8'(i); addrs[i] = inAdd;
            tick();
            vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL wrap_count%0d got=%0d exp=1", i, count); end
            if (i >= 2) begin
                vectors++;
                if (wrEn !== 1'b1 || addWr !== addrs[i-1] || dadoWr !== 8'(i - 1)) begin
                    miscompares++; $display("FAIL wrap_write%0d got %0b/%0d/%h exp 1/%0d/%h", i - 1, wrEn, addWr, dadoWr, addrs[i-1], 8'(i - 1));
                end
            end
        end
        inValid = 1'b0;
        tick();
        vectors++; if (wrEn !== 1'b1 || addWr !== addrs[10] || dadoWr !== 8'h0A) begin miscompares++; $display("FAIL wrap_last got %0b/%0d/%h exp 1/%0d/0a", wrEn, addWr, dadoWr, addrs[10]); end
        tick();
        vectors++; if (wrEn !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL wrap_idle got %0b/%0d exp 0/0", wrEn, count); end
    endtask

    task automatic test_random();
        logic [DW:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 49) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            inValid = ($urandom_range(0, 9) < 7);
            inAdd   = AW'($urandom);
            inDado  = DW'($urandom);
            tick();
            addQ1 = AW'($urandom); addQ2 = AW'($urandom); #1;
            e1 = ref_fwd(addQ1); e2 = ref_fwd(addQ2);
            vectors++; if (wrEn !== m_v) begin miscompares++; $display("FAIL rnd_wrEn@%0d got=%0b exp=%0b", n, wrEn, m_v); end
            if (m_v) begin
                vectors++; if (addWr !== m_a || dadoWr !== m_d) begin miscompares++; $display("FAIL rnd_port@%0d got %0d/%h exp %0d/%h", n, addWr, dadoWr, m_a, m_d); end
            end
            vectors++; if (count !== CW'(m_q.size())) begin miscompares++; $display("FAIL rnd_count@%0d got=%0d exp=%0d", n, count, m_q.size()); end
            vectors++; if (inReady !== ((m_q.size() < DEPTH) && !flush)) begin miscompares++; $display("FAIL rnd_ready@%0d got=%0b", n, inReady); end
            vectors++; if ({hit1, fwd1} !== e1) begin miscompares++; $display("FAIL rnd_fwd1@%0d got %0b/%h exp %0b/%h", n, hit1, fwd1, e1[DW], e1[DW-1:0]); end
            vectors++; if ({hit2, fwd2} !== e2) begin miscompares++; $display("FAIL rnd_fwd2@%0d got %0b/%h exp %0b/%h", n, hit2, fwd2, e2[DW], e2[DW-1:0]); end
        end
        rst = 1'b0; flush = 1'b0; stall = 1'b0; inValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_fwd();
        test_flush();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
